// File: rtl/sparse_stream_pkg.sv
// Shared token encoding and helpers for the sparse stream pipeline.
// A token is {ctrl, payload}; control tokens carry a type in [LVL_W+1:LVL_W].
package sparse_stream_pkg;

   localparam int DATA_W = 16;
   localparam int LVL_W  = 8;
   localparam int TOK_W  = DATA_W + 1;

   typedef enum logic [1:0] {
      CTRL_STOP = 2'b00,
      CTRL_DONE = 2'b01
   } ctrl_t;

   typedef enum logic [1:0] {
      WAIT_OUTER,
      SCAN,
      WAIT_DONE
   } crd_drop_state_t;

   function automatic logic is_ctrl(input logic [TOK_W-1:0] t);
      return t[TOK_W-1];
   endfunction

   function automatic logic is_stop(input logic [TOK_W-1:0] t);
      return t[TOK_W-1] && (t[LVL_W+1:LVL_W] == CTRL_STOP);
   endfunction

   function automatic logic is_done(input logic [TOK_W-1:0] t);
      return t[TOK_W-1] && (t[LVL_W+1:LVL_W] == CTRL_DONE);
   endfunction

   function automatic logic [LVL_W-1:0] stop_level(input logic [TOK_W-1:0] t);
      return t[LVL_W-1:0];
   endfunction

endpackage

// File: rtl/crd_drop_stream_reg.sv
// One-entry registered output slot: accepts a load when empty or when its
// current entry drains in the same cycle.
module stream_reg #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         vis_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic         can_load_o,
   output logic [W-1:0] out_data_o,
   output logic         out_valid_o,
   input  logic         out_ready_i
);

   logic         vld_q;
   logic [W-1:0] data_q;
   logic         drain;

   // A disabled tile hides its entry so nothing can drain while it is off.
   assign out_valid_o = vld_q & vis_i;
   assign out_data_o  = data_q;
   assign drain       = out_valid_o & out_ready_i;
   assign can_load_o  = en_i & vis_i & (~vld_q | out_ready_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else if (en_i) begin
         if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
         end else if (drain) begin
            vld_q  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/crd_drop.sv
// Drops outer coordinates whose intersected inner fiber is empty; the inner
// stream passes through untouched.
module crd_drop
   import sparse_stream_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             tile_en,
   input  logic [TOK_W-1:0] outer_crd_in,
   input  logic             outer_crd_in_valid,
   output logic             outer_crd_in_ready,
   input  logic [TOK_W-1:0] inner_crd_in,
   input  logic             inner_crd_in_valid,
   output logic             inner_crd_in_ready,
   output logic [TOK_W-1:0] outer_crd_out,
   output logic             outer_crd_out_valid,
   input  logic             outer_crd_out_ready,
   output logic [TOK_W-1:0] inner_crd_out,
   output logic             inner_crd_out_valid,
   input  logic             inner_crd_out_ready,
   output logic             protocol_err
);

   crd_drop_state_t  state_q, state_d;
   logic [TOK_W-1:0] hold_q, hold_d;
   logic             seen_q, seen_d;
   logic             err_q, err_d;
   logic             run_q;
   logic             act;
   logic             o_can_raw, i_can_raw, o_can, i_can;
   logic             o_load, i_load;
   logic [TOK_W-1:0] o_data;

   // run_q keeps the readies low for the first enabled cycle after reset.
   assign act   = clk_en & tile_en & run_q;
   assign o_can = o_can_raw & run_q;
   assign i_can = i_can_raw & run_q;
   assign protocol_err = err_q;

   stream_reg #(.W(TOK_W)) u_outer_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (clk_en),
      .vis_i       (tile_en),
      .load_i      (o_load),
      .data_i      (o_data),
      .can_load_o  (o_can_raw),
      .out_data_o  (outer_crd_out),
      .out_valid_o (outer_crd_out_valid),
      .out_ready_i (outer_crd_out_ready)
   );

   stream_reg #(.W(TOK_W)) u_inner_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (clk_en),
      .vis_i       (tile_en),
      .load_i      (i_load),
      .data_i      (inner_crd_in),
      .can_load_o  (i_can_raw),
      .out_data_o  (inner_crd_out),
      .out_valid_o (inner_crd_out_valid),
      .out_ready_i (inner_crd_out_ready)
   );

   always_comb begin
      state_d            = state_q;
      hold_d             = hold_q;
      seen_d             = seen_q;
      err_d              = err_q;
      o_load             = 1'b0;
      i_load             = 1'b0;
      o_data             = outer_crd_in;
      outer_crd_in_ready = 1'b0;
      inner_crd_in_ready = 1'b0;
      if (act) begin
         case (state_q)
            WAIT_OUTER: begin
               outer_crd_in_ready = o_can;
               if (outer_crd_in_valid && o_can) begin
                  if (!is_ctrl(outer_crd_in)) begin
                     hold_d  = outer_crd_in;
                     seen_d  = 1'b0;
                     state_d = SCAN;
                  end else if (is_stop(outer_crd_in)) begin
                     o_load = 1'b1;
                  end else if (is_done(outer_crd_in)) begin
                     state_d = WAIT_DONE;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            SCAN: begin
               // The first inner coordinate releases the held outer one.
               if (!is_ctrl(inner_crd_in))
                  inner_crd_in_ready = seen_q ? i_can : (i_can & o_can);
               else if (is_done(inner_crd_in))
                  inner_crd_in_ready = i_can & o_can;
               else
                  inner_crd_in_ready = i_can;
               if (inner_crd_in_valid && inner_crd_in_ready) begin
                  if (!is_ctrl(inner_crd_in)) begin
                     i_load = 1'b1;
                     if (!seen_q) begin
                        o_load = 1'b1;
                        o_data = hold_q;
                        seen_d = 1'b1;
                     end
                  end else if (is_stop(inner_crd_in)) begin
                     i_load  = 1'b1;
                     state_d = WAIT_OUTER;
                  end else if (is_done(inner_crd_in)) begin
                     // Early done: terminate both streams so consumers finish.
                     i_load  = 1'b1;
                     o_load  = 1'b1;
                     o_data  = inner_crd_in;
                     err_d   = 1'b1;
                     state_d = WAIT_DONE;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            WAIT_DONE: begin
               inner_crd_in_ready = is_done(inner_crd_in) ? (i_can & o_can) : 1'b1;
               if (inner_crd_in_valid && inner_crd_in_ready) begin
                  if (is_done(inner_crd_in)) begin
                     i_load  = 1'b1;
                     o_load  = 1'b1;
                     o_data  = inner_crd_in;
                     state_d = WAIT_OUTER;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            default: state_d = WAIT_OUTER;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_OUTER;
         hold_q  <= '0;
         seen_q  <= 1'b0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
      end else if (clk_en) begin
         run_q   <= 1'b1;
         state_q <= tile_en ? state_d : WAIT_OUTER;
         hold_q  <= hold_d;
         seen_q  <= seen_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_crd_drop.sv
// Directed bench for crd_drop: token streams in, collected outputs compared
// against hand-written expected sequences.
module tb_crd_drop;

   logic        clk = 1'b0;
   logic        rst_n, clk_en, tile_en;
   logic [16:0] outer_crd_in, inner_crd_in, outer_crd_out, inner_crd_out;
   logic        outer_crd_in_valid, outer_crd_in_ready;
   logic        inner_crd_in_valid, inner_crd_in_ready;
   logic        outer_crd_out_valid, outer_crd_out_ready;
   logic        inner_crd_out_valid, inner_crd_out_ready;
   logic        protocol_err;

   crd_drop dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .clk_en              (clk_en),
      .tile_en             (tile_en),
      .outer_crd_in        (outer_crd_in),
      .outer_crd_in_valid  (outer_crd_in_valid),
      .outer_crd_in_ready  (outer_crd_in_ready),
      .inner_crd_in        (inner_crd_in),
      .inner_crd_in_valid  (inner_crd_in_valid),
      .inner_crd_in_ready  (inner_crd_in_ready),
      .outer_crd_out       (outer_crd_out),
      .outer_crd_out_valid (outer_crd_out_valid),
      .outer_crd_out_ready (outer_crd_out_ready),
      .inner_crd_out       (inner_crd_out),
      .inner_crd_out_valid (inner_crd_out_valid),
      .inner_crd_out_ready (inner_crd_out_ready),
      .protocol_err        (protocol_err)
   );

   always #5 clk = ~clk;

   localparam logic [16:0] DN = 17'h10100;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [16:0] oq[$], iq[$], exp_o[$], exp_i[$], got_o[$], got_i[$];
   bit          seen_m, err_exp, err_scn, err_arm;

   function automatic logic [16:0] D(input int v);
      return {1'b0, v[15:0]};
   endfunction

   function automatic logic [16:0] S(input int l);
      return {1'b1, 6'b0, 2'b00, l[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bp: 0 = both ready, 1 = outer ready toggles and inner stalls mid-fiber, 2 = no readies
   task automatic run(input string name, input int budget, input int bp, input bit need_end);
      int oi, ii, cyc;
      bit fin;
      oi = 0; ii = 0; fin = 0; err_arm = 0;
      got_o.delete(); got_i.delete();
      for (cyc = 0; cyc < budget && !fin; cyc++) begin
         outer_crd_in_valid = (oi < oq.size());
         outer_crd_in       = outer_crd_in_valid ? oq[oi] : '0;
         inner_crd_in_valid = (ii < iq.size());
         inner_crd_in       = inner_crd_in_valid ? iq[ii] : '0;
         case (bp)
            0:       begin outer_crd_out_ready = 1'b1; inner_crd_out_ready = 1'b1; end
            1:       begin
               outer_crd_out_ready = (cyc % 2 == 0);
               inner_crd_out_ready = !(cyc >= 4 && cyc < 9);
            end
            default: begin outer_crd_out_ready = 1'b0; inner_crd_out_ready = 1'b0; end
         endcase
         @(negedge clk);
         chk({name, " protocol_err"}, protocol_err, err_exp);
         if (outer_crd_out_valid && !outer_crd_out_ready && inner_crd_in_valid &&
             !inner_crd_in[16] && !seen_m)
            chk({name, " stall inner_ready"}, inner_crd_in_ready, 0);
         if (outer_crd_in_valid && outer_crd_in_ready) begin
            if (!outer_crd_in[16]) seen_m = 1'b0;
            oi++;
         end
         if (inner_crd_in_valid && inner_crd_in_ready) begin
            if (!inner_crd_in[16]) seen_m = 1'b1;
            if (err_scn && inner_crd_in == DN) err_arm = 1'b1;
            ii++;
         end
         if (outer_crd_out_valid && outer_crd_out_ready) got_o.push_back(outer_crd_out);
         if (inner_crd_out_valid && inner_crd_out_ready) got_i.push_back(inner_crd_out);
         @(posedge clk); #1;
         if (err_arm) err_exp = 1'b1;
         fin = (got_o.size() == exp_o.size()) && (got_i.size() == exp_i.size());
      end
      outer_crd_in_valid = 1'b0; inner_crd_in_valid = 1'b0;
      outer_crd_in = '0; inner_crd_in = '0;
      if (need_end) begin
         chk({name, " finished"}, fin, 1);
         chk({name, " outer count"}, got_o.size(), exp_o.size());
         chk({name, " inner count"}, got_i.size(), exp_i.size());
         for (int i = 0; i < exp_o.size() && i < got_o.size(); i++)
            chk($sformatf("%s outer[%0d]", name, i), got_o[i], exp_o[i]);
         for (int i = 0; i < exp_i.size() && i < got_i.size(); i++)
            chk($sformatf("%s inner[%0d]", name, i), got_i[i], exp_i[i]);
      end
   endtask

   task automatic check_idle(input string name);
      chk({name, " outer_out_valid"}, outer_crd_out_valid, 0);
      chk({name, " inner_out_valid"}, inner_crd_out_valid, 0);
      chk({name, " outer_in_ready"}, outer_crd_in_ready, 0);
      chk({name, " inner_in_ready"}, inner_crd_in_ready, 0);
      chk({name, " outer_out data"}, outer_crd_out, 0);
      chk({name, " inner_out data"}, inner_crd_out, 0);
      chk({name, " protocol_err"}, protocol_err, 0);
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0; err_exp = 1'b0; seen_m = 1'b0; err_scn = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_idle(name);
      rst_n = 1'b1;
   endtask

   task automatic load_scn1();
      oq    = '{D(1), D(3), S(0), DN};
      iq    = '{D(2), S(0), D(5), D(6), S(1), DN};
      exp_o = '{D(1), D(3), S(0), DN};
      exp_i = iq;
   endtask

   task automatic load_scn2();
      oq    = '{D(0), D(4), D(7), S(0), DN};
      iq    = '{D(9), S(0), S(0), D(2), S(1), DN};
      exp_o = '{D(0), D(7), S(0), DN};
      exp_i = iq;
   endtask

   initial begin
      rst_n = 1'b0; clk_en = 1'b1; tile_en = 1'b1;
      outer_crd_in = '0; inner_crd_in = '0;
      outer_crd_in_valid = 1'b0; inner_crd_in_valid = 1'b0;
      outer_crd_out_ready = 1'b0; inner_crd_out_ready = 1'b0;
      do_reset("reset");

      load_scn1();
      run("keep", 200, 0, 1);

      load_scn2();
      run("drop", 200, 0, 1);

      oq    = '{D(5), S(0), DN};
      iq    = '{S(1), DN};
      exp_o = '{S(0), DN};
      exp_i = iq;
      run("alldrop", 200, 0, 1);

      load_scn2();
      run("backpr", 400, 1, 1);

      oq    = '{D(3), S(0), DN};
      iq    = '{DN};
      exp_o = '{DN};
      exp_i = '{DN};
      err_scn = 1'b1;
      run("perr", 200, 0, 1);
      repeat (3) @(posedge clk);
      #1 chk("perr sticky", protocol_err, 1);
      do_reset("perr reset");

      // Park one token in each output slot mid-SCAN, then reset asynchronously.
      oq    = '{D(1)};
      iq    = '{D(2)};
      exp_o = '{D(1)};
      exp_i = '{D(2)};
      run("park", 6, 2, 0);
      chk("park outer_valid", outer_crd_out_valid, 1);
      chk("park inner_valid", inner_crd_out_valid, 1);
      chk("park outer data", outer_crd_out, D(1));
      chk("park inner data", inner_crd_out, D(2));
      #3 rst_n = 1'b0;
      #1 check_idle("async reset");
      err_exp = 1'b0; seen_m = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; tile_en = 1'b0;
      outer_crd_in = D(1); outer_crd_in_valid = 1'b1;
      inner_crd_in = D(2); inner_crd_in_valid = 1'b1;
      outer_crd_out_ready = 1'b1; inner_crd_out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("tile off outer_in_ready c%0d", c), outer_crd_in_ready, 0);
         chk($sformatf("tile off inner_in_ready c%0d", c), inner_crd_in_ready, 0);
         chk($sformatf("tile off outer_out_valid c%0d", c), outer_crd_out_valid, 0);
      end
      @(posedge clk); #1;
      tile_en = 1'b1;
      outer_crd_in_valid = 1'b0; inner_crd_in_valid = 1'b0;
      load_scn1();
      run("rerun", 200, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/crd_drop.md
Name: crd_drop

Overview:
- Coordinate-dropper stage directly downstream of the intersect unit in the sparse stream pipeline.
- Consumes an outer-level coordinate stream and the intersect unit's inner coordinate output.
- Removes every outer coordinate whose inner fiber came out of intersection empty.
- Passes the inner stream through unchanged, so downstream writers never store empty fibers.

Parameters:
- DATA_W, 16, payload width; token width is DATA_W+1, with the MSB as the control flag.
- LVL_W, 8, stop-token level field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- clk_en  in  1  global clock enable; when low, all state holds
- tile_en  in  1  block enable; when low, all valids/readies are 0 and the FSM is held in WAIT_OUTER
- outer_crd_in  in  17  outer coordinate token
- outer_crd_in_valid  in  1
- outer_crd_in_ready  out  1
- inner_crd_in  in  17  inner token (from intersect coord_out)
- inner_crd_in_valid  in  1
- inner_crd_in_ready  out  1
- outer_crd_out  out  17  filtered outer stream
- outer_crd_out_valid  out  1
- outer_crd_out_ready  in  1
- inner_crd_out  out  17  inner stream, passed through
- inner_crd_out_valid  out  1
- inner_crd_out_ready  in  1
- protocol_err  out  1  sticky; cleared only by reset

Behaviour:
- Token encoding:
  - bit16=0: data coordinate.
  - bit16=1 with bits[9:8]=00: stop token, level in bits[7:0].
  - bit16=1 with bits[9:8]=01: done token.
- Handshake:
  - A transfer occurs when valid&&ready in the same cycle.
  - Valid must not depend combinationally on ready.
- Output stages:
  - Each output is a one-entry register: load when empty, or when draining in the same cycle.
  - Latency: 1 cycle input-to-output.
  - Inner pass-through sustains 1 token/cycle with both out_readys high.
- Reset values: all *_valid=0, all *_ready=0, data outputs 0, protocol_err=0, FSM=WAIT_OUTER, seen=0.
- FSM:
  - WAIT_OUTER: outer_crd_in_ready=1 when the outer output slot can accept; inner_crd_in_ready=0.
    - Data coordinate: latch into hold_crd, clear seen, go to SCAN.
    - Stop token: forward to outer_crd_out unchanged; stay.
    - Done token: go to WAIT_DONE.
  - SCAN: outer_crd_in_ready=0. Accept inner tokens whenever the inner output slot can accept.
    - Inner data with seen=0: additionally requires the outer output slot to accept; load hold_crd to outer_crd_out and set seen=1 in the same cycle. Otherwise stall inner (ready=0).
    - Inner data with seen=1: forward it.
    - Inner stop: forward it; go to WAIT_OUTER. The outer coordinate is dropped if seen=0.
    - Inner done: protocol_err=1; forward done; go to WAIT_DONE.
  - WAIT_DONE: outer_crd_in_ready=0; accept inner tokens.
    - Inner stop or data: protocol_err=1; discard.
    - Inner done: requires both output slots free (or draining); emit done on both outputs in the same cycle; go to WAIT_OUTER for the next tile.
- Outer stop tokens are always forwarded, even when every coordinate of the fiber was dropped.
- Inner stop tokens are never altered.
- clk_en=0: no transfers, readies 0, registers frozen, valids held.
- Asynchronous reset mid-stream discards held tokens immediately.

Decomposition:
- Package sparse_stream_pkg:
  - Token width, LVL_W.
  - Control-type enum: STOP=2'b00, DONE=2'b01.
  - Helper functions is_ctrl/is_stop/is_done/stop_level.
  - FSM state enum crd_drop_state_t.
- Sub-module stream_reg (one-entry registered valid/ready stage), instantiated twice, for the outer and inner outputs.

Test Plan:
- All kept: outer [1,3,S0,D]; inner [2,S0,5,6,S1,D], both ready=1 → outer_out [1,3,S0,D]; inner_out identical to inner input; protocol_err=0.
- Empty fiber dropped: outer [0,4,7,S0,D]; inner [9,S0,S0,2,S1,D] → outer_out [0,7,S0,D]; inner_out unchanged.
- All dropped: outer [5,S0,D]; inner [S1,D] → outer_out [S0,D]; inner_out [S1,D].
- Backpressure: scenario 2 with outer_crd_out_ready toggled 1010… and inner_crd_out_ready held 0 for 5 cycles mid-fiber → identical token sequences, no duplication or loss; inner_crd_in_ready=0 while the outer slot is full and seen=0.
- Protocol error: outer [3,S0,D]; inner [D] → protocol_err=1 the cycle after inner done is accepted; both outputs end with D; the error stays set until rst_n low.
- Reset/enable: assert rst_n low mid-SCAN with outputs valid → all valids 0 immediately; hold tile_en=0 for 4 cycles → readies 0; then rerun scenario 1 with correct output.
